// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection for a shared tri-state bus.
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   req          level request per requester
//   lock         per requester; suppresses hold pre-emption of the owner
//   grant        registered one-hot (or zero) bus enable
//   grant_id     registered index of the owner, 0 when not busy
//   busy         registered, high while grant is non-zero
//   hold_expired registered one-cycle pulse when the hold limit is hit with
//                another requester waiting
// Also contains encoder: one-hot to binary index (zero input gives 0).

module encoder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]         onehot_i,
  output logic [$clog2(WIDTH)-1:0] index_o
);
  localparam int unsigned IW = $clog2(WIDTH);

  // OR of the indices of set bits; exact for one-hot inputs
  always_comb begin
    index_o = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (onehot_i[i]) index_o = index_o | IW'(i);
    end
  end
endmodule

module bus_arbiter #(
  parameter int unsigned requester_num = 4,
  parameter int unsigned max_hold      = 15
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [requester_num-1:0]         req,
  input  logic [requester_num-1:0]         lock,
  output logic [requester_num-1:0]         grant,
  output logic [$clog2(requester_num)-1:0] grant_id,
  output logic                             busy,
  output logic                             hold_expired
);
  localparam int unsigned N  = requester_num;
  localparam int unsigned IW = $clog2(requester_num);
  // Keep at least one counter bit so max_hold=0 still elaborates
  localparam int unsigned HW = (max_hold == 0) ? 1 : $clog2(max_hold + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(max_hold);
  localparam logic [HW-1:0] HOLD_LOAD = (max_hold == 0) ? HW'(0) : HW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic            busy_q;
  logic            expired_q, expired_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [IW-1:0]   last_q, last_d;
  logic            seen_q, seen_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic            owner_req;
  logic            owner_lock;
  logic            others_req;
  logic            preempt;

  // Round-robin search starting just after the previous owner
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= int'(N); k++) begin
      cand = IW'((int'(last_q) + k) % int'(N));
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // grant_q is the owner mask while OWNED, so masking avoids indexing
  assign owner_req  = |(req & grant_q);
  assign owner_lock = |(lock & grant_q);
  assign others_req = |(req & ~grant_q);
  assign preempt    = (max_hold != 0) && (hold_q == HOLD_MAX) && !owner_lock && others_req;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    hold_d    = hold_q;
    last_d    = last_q;
    seen_d    = seen_q;
    expired_d = 1'b0;

    case (state_q)
      ST_OWNED: begin
        // Release takes precedence; both lead to a single TURN cycle
        if (!owner_req || preempt) begin
          state_d = ST_TURN;
          grant_d = '0;
          hold_d  = '0;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        if (win_found) begin
          state_d = ST_OWNED;
          grant_d = N'(1) << win_idx;
          last_d  = win_idx;
          hold_d  = HOLD_LOAD;
          seen_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          hold_d  = '0;
        end
      end
    endcase

    // Pulse coincides with the first owned cycle at the hold limit
    if ((state_d == ST_OWNED) && (max_hold != 0) && (hold_d == HOLD_MAX) &&
        !seen_d && (|(req & ~grant_d))) begin
      expired_d = 1'b1;
      seen_d    = 1'b1;
    end
  end

  encoder #(.WIDTH(N)) u_encoder (
    .onehot_i (grant_d),
    .index_o  (grant_id_d)
  );

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      expired_q  <= 1'b0;
      hold_q     <= '0;
      last_q     <= IW'(N - 1);
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= |grant_d;
      expired_q  <= expired_d;
      hold_q     <= hold_d;
      last_q     <= last_d;
      seen_q     <= seen_d;
    end
  end

  assign grant        = grant_q;
  assign grant_id     = grant_id_q;
  assign busy         = busy_q;
  assign hold_expired = expired_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios plus randomized traffic
// checked against an ownership-level reference model.
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int MH = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       hold_expired;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the bus, for how long, and the pulse state
  int m_owner;
  int m_last;
  int m_cnt;
  bit m_pulsed;
  bit m_exp;

  bus_arbiter #(.requester_num(N), .max_hold(MH)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .req          (req),
    .lock         (lock),
    .grant        (grant),
    .grant_id     (grant_id),
    .busy         (busy),
    .hold_expired (hold_expired)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner  = -1;
    m_last   = N - 1;
    m_cnt    = 0;
    m_pulsed = 0;
    m_exp    = 0;
  endtask

  // Apply the arbitration rules for one rising edge with inputs r/l
  task automatic model_edge(input logic [3:0] r, input logic [3:0] l);
    logic [3:0] mine;
    bit         others;
    bit         give_up;
    int         c;
    m_exp = 0;
    if (m_owner >= 0) begin
      mine    = 4'(1 << m_owner);
      others  = (r & ~mine) != 4'b0;
      give_up = ((r & mine) == 4'b0) ||
                (m_cnt == MH && (l & mine) == 4'b0 && others);
      if (give_up) begin
        m_owner = -1;
        m_cnt   = 0;
      end else if (m_cnt < MH) begin
        m_cnt++;
      end
    end else begin
      m_cnt = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (m_owner < 0 && ((r >> c) & 4'b1) != 4'b0) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_last   = m_owner;
        m_cnt    = 1;
        m_pulsed = 0;
      end
    end
    if (m_owner >= 0 && m_cnt == MH && !m_pulsed &&
        (r & ~4'(1 << m_owner)) != 4'b0) begin
      m_exp    = 1;
      m_pulsed = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(req, lock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0;
    lock  = 4'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b0;
    lock  = 4'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({grant, grant_id, busy, hold_expired} !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got grant=%b id=%0d busy=%b he=%b want all 0",
               grant, grant_id, busy, hold_expired);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0100;
    tick();
    n_cmp++;
    if (grant !== 4'b0100 || grant_id !== 2'd2 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL first_grant: got grant=%b id=%0d busy=%b want 0100/2/1",
               grant, grant_id, busy);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({grant, grant_id, busy, hold_expired} !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got grant=%b id=%0d busy=%b he=%b want all 0",
               grant, grant_id, busy, hold_expired);
    end
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (grant !== 4'b0001 || grant_id !== 2'd0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_regrant: got grant=%b id=%0d want 0001/0", grant, grant_id);
    end
    req = 4'b0;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] want;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      want = 4'(1 << order[i]);
      tick();
      n_cmp++;
      if (grant !== want || grant_id !== 2'(order[i])) begin
        n_bad++;
        $display("FAIL rr_grant[%0d]: got grant=%b id=%0d want %b/%0d",
                 i, grant, grant_id, want, order[i]);
      end
      tick();
      tick();
      n_cmp++;
      if (grant !== want) begin
        n_bad++;
        $display("FAIL rr_hold[%0d]: got grant=%b want %b", i, grant, want);
      end
      req = req & ~want;
      tick();
      n_cmp++;
      if (grant !== 4'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_turn[%0d]: got grant=%b busy=%b want 0000/0", i, grant, busy);
      end
      req = req | want;
    end
    req = 4'b0;
    tick();
    tick();
  endtask

  task automatic test_preempt(input bit locked);
    int bad = 0;
    do_reset();
    lock = locked ? 4'b0010 : 4'b0000;
    req  = 4'b0010;
    tick();
    tick();
    req = 4'b1010;
    for (int c = 3; c <= 14; c++) begin
      tick();
      if (hold_expired !== 1'b0 || grant !== 4'b0010) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL hold_early(lock=%0d): got %0d bad cycles want 0", locked, bad);
    end
    tick();
    n_cmp++;
    if (hold_expired !== 1'b1 || grant !== 4'b0010) begin
      n_bad++;
      $display("FAIL hold_pulse(lock=%0d): got he=%b grant=%b want 1/0010",
               locked, hold_expired, grant);
    end
    if (locked) begin
      bad = 0;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (hold_expired !== 1'b0 || grant !== 4'b0010) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL lock_keep: got %0d bad cycles want 0", bad);
      end
      req = 4'b1000;
    end
    tick();
    n_cmp++;
    if (grant !== 4'b0 || hold_expired !== 1'b0) begin
      n_bad++;
      $display("FAIL preempt_turn(lock=%0d): got grant=%b he=%b want 0000/0",
               locked, grant, hold_expired);
    end
    tick();
    n_cmp++;
    if (grant !== 4'b1000 || grant_id !== 2'd3) begin
      n_bad++;
      $display("FAIL preempt_next(lock=%0d): got grant=%b id=%0d want 1000/3",
               locked, grant, grant_id);
    end
    req  = 4'b0;
    lock = 4'b0;
    tick();
    tick();
  endtask

  task automatic test_single();
    int bad = 0;
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (grant !== 4'b0100 || hold_expired !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL single_hold: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_idle_return();
    req = 4'b0;
    tick();
    n_cmp++;
    if (grant !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      n_bad++;
      $display("FAIL idle_turn: got grant=%b busy=%b id=%0d want 0", grant, busy, grant_id);
    end
    tick();
    n_cmp++;
    if (grant !== 4'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_state: got grant=%b busy=%b want 0000/0", grant, busy);
    end
    req = 4'b0010;
    tick();
    n_cmp++;
    if (grant !== 4'b0010 || grant_id !== 2'd1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_regrant: got grant=%b id=%0d busy=%b want 0010/1/1",
               grant, grant_id, busy);
    end
    req = 4'b0;
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [3:0] eg;
    logic [1:0] eid;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0)  req  = req ^ 4'(1 << b);
        if ($urandom_range(15) == 0) lock = lock ^ 4'(1 << b);
      end
      tick();
      eg  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
      eid = (m_owner >= 0) ? 2'(m_owner) : 2'b0;
      n_cmp++;
      if (grant !== eg || grant_id !== eid || busy !== (m_owner >= 0) ||
          hold_expired !== m_exp) begin
        n_bad++;
        $display("FAIL rand[%0d]: got grant=%b id=%0d busy=%b he=%b want %b/%0d/%b/%b",
                 c, grant, grant_id, busy, hold_expired, eg, eid, (m_owner >= 0), m_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_round_robin();
    test_preempt(1'b0);
    test_preempt(1'b1);
    test_single();
    test_idle_return();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter sharing one tri-state data bus among `requester_num` masters. Produces registered one-hot bus-enable grants that drive the `en` inputs of the shared `tri_state_buffer`, plus the encoded owner index for downstream muxing. A mandatory one-cycle turnaround between owners prevents bus contention. A hold counter pre-empts owners that keep the bus past `max_hold` cycles unless they assert `lock`.

## Interface
- `requester_num`, default 4: number of requesters, ≥2.
- `max_hold`, default 15: cycles an unlocked owner may hold the bus while others wait. 0 disables pre-emption.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `req`  in  `requester_num`  bus request per requester, level-sensitive.
- `lock`  in  `requester_num`  per requester; when high for the current owner, pre-emption is suppressed.
- `grant`  out  `requester_num`  one-hot or zero bus enable, registered.
- `grant_id`  out  `$clog2(requester_num)`  index of current owner. Valid only while `busy`=1; 0 otherwise.
- `busy`  out  1  high when `grant` is non-zero.
- `hold_expired`  out  1  one-cycle pulse when the owner's hold count reaches `max_hold` while another request is pending.

## Operation
- FSM states:
  - IDLE: `grant`=0.
  - OWNED: exactly one `grant` bit set.
  - TURN: `grant`=0 for one cycle.
- Transitions:
  - IDLE→OWNED when `|req`. The winner is selected from the `req` value sampled on that edge.
  - OWNED→TURN when the owner's `req`=0 (release).
  - OWNED→TURN on pre-emption, which requires all three: `hold_cnt`==`max_hold`, `max_hold`≠0, and `lock[owner]`=0, while some other `req` is high.
  - TURN→OWNED if `|req` at that edge, otherwise TURN→IDLE.
- Winner selection: round-robin. Search starts at `(last_owner+1) mod requester_num` and wraps, and the first set `req` bit wins.
  - `last_owner` updates on every grant.
  - Reset value of `last_owner` is `requester_num-1`, so requester 0 has top priority after reset.
  - A pre-empted owner that still requests competes normally. It is lowest priority in the next search.
- Hold counter (`hold_cnt`):
  - Width `$clog2(max_hold+1)`.
  - Loaded to 1 on entry to OWNED, incremented each further OWNED cycle, saturates at `max_hold`.
  - Cleared to 0 in IDLE and TURN.
- `hold_expired`: pulses on the first cycle in which `hold_cnt`==`max_hold` with another request pending. It pulses whether or not `lock` suppresses the pre-emption, and at most once per ownership.
- Simultaneous release and pre-emption: treated as release. Single transition to TURN, `hold_expired` still pulses if its condition holds.
- The owner's `req` dropping while `lock` is high is still a release. `lock` only blocks pre-emption.
- `req` bits of non-owners may toggle freely. Only the value at the arbitration edge matters.
- `grant_id` is generated with the codebase `encoder` from the one-hot grant vector and registered alongside it.

## Timing
- Reset asserted, asynchronously and at any time including mid-ownership:
  - `grant`=0, `grant_id`=0, `busy`=0, `hold_expired`=0.
  - State IDLE, `hold_cnt`=0, `last_owner`=`requester_num-1`.
- Reset deassertion: first arbitration on the first rising edge after `reset` goes high.
- Grant latency: with `req` high before edge N in IDLE, `grant` is visible after edge N, i.e. 1 cycle.
- Handover: owner drops `req` before edge N. `grant`=0 after edge N (TURN). New `grant` after edge N+1. Minimum gap between owners is exactly 1 cycle.
- A single requester holding `req` high is never pre-empted, regardless of `hold_cnt`.
- All outputs are registered. No combinational path from `req`/`lock` to outputs.

## Test plan
- Reset mid-ownership: requester 2 owns the bus. Drive `reset`=0 asynchronously between edges → all outputs 0 immediately. After release, `req`=4'b1111 grants requester 0 after one edge.
- Round-robin: `req`=4'b1111 held, each owner drops `req` for 1 cycle after 3 cycles of ownership → grant order 0,1,2,3,0 with one zero-grant TURN cycle between each.
- Pre-emption: `max_hold`=15, requester 1 holds, `lock`=0, requester 3 requests from cycle 2 → `hold_expired` pulses on the 15th owned cycle, TURN next, then `grant`=4'b1000, `grant_id`=3.
- Lock: same as pre-emption but `lock[1]`=1 → `hold_expired` pulses once, requester 1 keeps the grant until it drops `req`, then requester 3 is granted after TURN.
- Single requester: only `req[2]` high for 100 cycles → `grant`=4'b0100 throughout, `hold_expired` never pulses.
- Idle return: owner releases with no other `req` → TURN then IDLE, `busy`=0. A new `req[1]` in IDLE is granted after one edge.
